// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial adder controller: sequences NBYTES byte additions through an external
// 8-bit adder, rippling the carry through a register, and returns {carry, sum}.
module byte_serial_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES:0]   out_sum,
  output logic                busy,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [8:0]          add_sum,
  output logic [1:0]          o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its payload stable while valid is high and ready is low.

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_carry;
  logic [IW-1:0]  r_idx;
  logic           w_accept;
  logic           w_last;
  logic           w_run;
  logic [7:0]     w_byte_a;
  logic [7:0]     w_byte_b;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_idx == LAST_IDX);
  // Adder inputs are forced to zero during reset even before the state register clears.
  assign w_run       = (r_state == S_RUN) && !rst;
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_valid   = (r_state == S_DONE);
  assign out_sum     = {r_carry, r_res};
  assign o_dbg_state = r_state;

  always_comb begin
    w_byte_a = 8'd0;
    w_byte_b = 8'd0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IW'(k)) begin
        w_byte_a = r_a[8*k +: 8];
        w_byte_b = r_b[8*k +: 8];
      end
    end
  end

  assign add_a   = w_run ? w_byte_a : 8'd0;
  assign add_b   = w_run ? w_byte_b : 8'd0;
  assign add_cin = w_run ? r_carry  : 1'b0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_res   <= '0;
            r_carry <= op_cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) r_res[8*k +: 8] <= add_sum[7:0];
          end
          r_carry <= add_sum[8];
          // Index parks on the last byte so it never wraps past NBYTES-1.
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for byte_serial_adder_ctrl (NBYTES=4) with a behavioural 8-bit adder
// closing the add_a/add_b/add_cin -> add_sum loop.
module tb_byte_serial_adder_ctrl;

  localparam int NB = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          op_cin;
  logic          out_valid;
  logic          out_ready;
  logic [32:0]   out_sum;
  logic          busy;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [8:0]    add_sum;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .o_dbg_state(dbg_state)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from an IDLE cycle; cin_seq bit k is the expected add_cin in RUN cycle k.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [32:0] exp, input logic [3:0] cin_seq,
                       input int stall, input bit scramble);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    out_ready = (stall == 0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk("busy_run", 64'(busy), 64'd1);
      chk("out_valid_run", 64'(out_valid), 64'd0);
      chk("add_a_seq", 64'(add_a), 64'(a[8*k +: 8]));
      chk("add_b_seq", 64'(add_b), 64'(b[8*k +: 8]));
      chk("add_cin_seq", 64'(add_cin), 64'(cin_seq[k]));
      if (scramble) begin
        op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("out_valid_done", 64'(out_valid), 64'd1);
    chk("out_sum", 64'(out_sum), 64'(exp));
    chk("add_a_done", 64'(add_a), 64'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      tick();
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_sum", 64'(out_sum), 64'(exp));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("out_valid_after", 64'(out_valid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_post_rst", 64'(in_ready), 64'd1);

    // Latency: accept edge, four RUN cycles, DONE on the fifth cycle.
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 4'b0010, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 4'b1111, 0, 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 33'h0_ACF1_3568, 4'b0110, 0, 1'b1);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001, 4'b0001, 0, 1'b0);
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000, 4'b0110, 3, 1'b0);

    // Reset during the second RUN cycle.
    op_a = 32'h5555_5555; op_b = 32'h5555_5555; op_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_add_a", 64'(add_a), 64'd0);
    chk("rst_mid_add_cin", 64'(add_cin), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_sum", 64'(out_sum), 64'd0);
    chk("rst_mid_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    #1;
    do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 33'h0_EFBE_D000, 4'b0010, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
